// File: rtl/addsub_serial_n.sv
// rtl/addsub_serial_n.sv - digit-serial add/subtract with masked operands, optional wait states, carry and overflow flags
module addsub_serial_n #(
    parameter int               WIDTH  = 8,
    parameter int               DIGIT  = 1,
    parameter int               DELAY  = 1,
    parameter logic [WIDTH-1:0] A_MASK = '0,
    parameter logic [WIDTH-1:0] B_MASK = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int MAXC  = (STEPS > DELAY) ? STEPS : DELAY;
    localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ADD, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [CW-1:0]    count;
    logic             carry;

    logic             load, last_wait, last_add;
    logic [DIGIT:0]   sum;
    logic [DIGIT-1:0] s;
    logic             c, c_msb;
    logic [WIDTH+DIGIT-1:0] out_cat;
    logic [WIDTH-1:0] b_eff;

    assign load      = start && (state == S_IDLE || state == S_DONE);
    assign last_wait = (count == CW'(DELAY - 1));
    assign last_add  = (count == CW'(STEPS - 1));
    assign sum       = {1'b0, a_reg[DIGIT-1:0]} + {1'b0, b_reg[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    assign s         = sum[DIGIT-1:0];
    assign c         = sum[DIGIT];
    // Carry into the top bit of a digit is recoverable from its sum bit and operand bits.
    assign c_msb     = s[DIGIT-1] ^ a_reg[DIGIT-1] ^ b_reg[DIGIT-1];
    assign out_cat   = {s, out};
    assign b_eff     = sub ? ~(b ^ B_MASK) : (b ^ B_MASK);

    assign busy = (state == S_WAIT) || (state == S_ADD);
    assign done = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = (DELAY > 0) ? S_WAIT : S_ADD;
            S_WAIT:         if (last_wait) state_nxt = S_ADD;
            S_ADD:          if (last_add) state_nxt = S_DONE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            out   <= '0;
            a_reg <= '0;
            b_reg <= '0;
            count <= '0;
            carry <= 1'b0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                a_reg <= a ^ A_MASK;
                b_reg <= b_eff;
                carry <= sub;
                count <= '0;
                out   <= '0;
                cout  <= 1'b0;
                ovf   <= 1'b0;
            end else if (state == S_WAIT) begin
                count <= last_wait ? '0 : count + 1'b1;
            end else if (state == S_ADD) begin
                out   <= out_cat[WIDTH+DIGIT-1:DIGIT];
                a_reg <= a_reg >> DIGIT;
                b_reg <= b_reg >> DIGIT;
                carry <= c;
                count <= last_add ? '0 : count + 1'b1;
                if (last_add) begin
                    cout <= c;
                    ovf  <= c_msb ^ c;
                end
            end
        end
    end
endmodule

// File: doc/addsub_serial_n.md
Name: addsub_serial_n

Overview:
Parametrised digit-serial adder/subtractor, the successor to the 8-bit bit-serial add block. Operands are captured on start, XOR-keyed with fixed obfuscation masks, then processed DIGIT bits per cycle, LSB digit first. An optional run of dummy wait states precedes the arithmetic. The block adds a subtract mode, carry-out and signed overflow flags, and back-to-back restart from DONE.

Parameters:
WIDTH, 8, operand/result width in bits; must be >= 2
DIGIT, 1, bits processed per ADD cycle; must divide WIDTH; STEPS = WIDTH/DIGIT
DELAY, 1, number of dummy WAIT cycles between load and first ADD step; 0 = go straight to ADD
A_MASK, 0, WIDTH-bit XOR key applied to a at load
B_MASK, 0, WIDTH-bit XOR key applied to b at load

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  launch operation; sampled only in IDLE or DONE
sub  input  1  0 = add, 1 = subtract; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
out  output  WIDTH  result register; final only while done=1
cout  output  1  carry out of MSB (sub: 1 = no borrow); valid while done=1
ovf  output  1  two's-complement overflow; valid while done=1
busy  output  1  high in WAIT and ADD
done  output  1  high in DONE

Behaviour:
- Reset (async, rst=1): state=IDLE; out, a_reg, b_reg, count, carry, cout, ovf = 0; busy=0, done=0. Reset mid-operation aborts with no partial result kept.
- Effective operands: A = a ^ A_MASK; B = b ^ B_MASK when sub=0, or ~(b ^ B_MASK) when sub=1.
- Result: out = (A + B + sub) mod 2^WIDTH, i.e. Ak+Bk or Ak-Bk, where Ak = a ^ A_MASK and Bk = b ^ B_MASK.
- States: IDLE, WAIT, ADD, DONE.
- IDLE with start=1: a_reg<=A, b_reg<=B, carry<=sub, count<=0, out<=0, cout<=0, ovf<=0; next state WAIT if DELAY>0, else ADD.
- IDLE with start=0: hold.
- WAIT: no datapath change; count<=count+1.
  - When count==DELAY-1: count<=0, next state ADD.
- ADD, each cycle:
  - {c, s} = a_reg[DIGIT-1:0] + b_reg[DIGIT-1:0] + carry, giving a DIGIT-bit sum s and carry c.
  - out <= {s, out[WIDTH-1:DIGIT]}.
  - a_reg, b_reg shift right by DIGIT, zero-filled.
  - carry <= c; count<=count+1.
- ADD, when count==STEPS-1:
  - cout <= c.
  - ovf <= carry into bit WIDTH-1 XOR c (bit-level carry inside the final digit).
  - count<=0; next state DONE.
- DONE: out, cout, ovf held; done=1. start=1 performs the same load as IDLE and goes directly to WAIT/ADD. start=0 holds.
- start asserted in WAIT or ADD is ignored; a, b and sub are don't-care outside the load cycle.
- Latency: with load on edge 0, done rises after edge DELAY+STEPS. Default configuration: 9 cycles.
- count width: enough bits for max(STEPS, DELAY) - 1.

Test Plan:
1. Defaults, masks 0, a=0x3C, b=0x05, sub=0, start 1 cycle -> busy for 9 cycles, then done=1, out=0x41, cout=0, ovf=0; outputs held until next start.
2. Defaults, a=0xFF, b=0x01 add -> out=0x00, cout=1, ovf=0; then start from DONE with a=0x7F, b=0x01 -> out=0x80, cout=0, ovf=1, with no IDLE cycle in between.
3. Defaults, sub=1, a=0x05, b=0x07 -> out=0xFE, cout=0 (borrow), ovf=0; sub=1, a=0x80, b=0x01 -> out=0x7F, cout=1, ovf=1.
4. A_MASK=0x19, B_MASK=0xBA, a=0x00, b=0x00, add -> out=0xD3, cout=0; a=0x19, b=0xBA -> out=0x00.
5. WIDTH=16, DIGIT=4, DELAY=0, a=0xFFFF, b=0x0001 -> done after 4 cycles, out=0x0000, cout=1; start pulses during busy are ignored and the result is unchanged.
6. Defaults, assert rst asynchronously at cycle 5 of an add -> all outputs 0 immediately, state IDLE; a subsequent start gives the correct result at the normal 9-cycle latency.
